// File: rtl/matmul_apb_slave.sv
// APB slave front-end for the matrix-multiply core: control register,
// operand line writes, overflow flags and scratchpad readback.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   psel_i .. paddr_i       APB request (paddr_i[4:0] region, upper bits line)
//   pready_o, pslverr_o,
//   prdata_o                APB response, valid only in the RESP cycle
//   busy_o, start_o,
//   control_o               core control and status
//   a_we_o, b_we_o, op_*    operand line write port to the core
//   sp_*                    scratchpad read port (data returns same cycle)
//   done_i, flags_i         core completion pulse and overflow flags
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [MAX_DIM-1:0]           pstrb_i,
    input  logic [BUS_WIDTH-1:0]         pwdata_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic [BUS_WIDTH-1:0]         prdata_o,
    output logic                         busy_o,
    output logic                         start_o,
    output logic [15:0]                  control_o,
    output logic                         a_we_o,
    output logic                         b_we_o,
    output logic [$clog2(MAX_DIM)-1:0]   op_line_o,
    output logic [BUS_WIDTH-1:0]         op_wdata_o,
    output logic [MAX_DIM-1:0]           op_wstrb_o,
    output logic                         sp_rd_en_o,
    output logic [1:0]                   sp_sel_o,
    output logic [2*$clog2(MAX_DIM)-1:0] sp_addr_o,
    input  logic [BUS_WIDTH-1:0]         sp_rdata_i,
    input  logic                         done_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]   flags_i
);

    localparam int LW     = $clog2(MAX_DIM);
    localparam int SW     = 2 * LW;
    localparam int FW     = MAX_DIM * MAX_DIM;
    localparam int LINE_W = ADDR_WIDTH - 5;

    localparam logic [LINE_W-1:0] MAX_LINE = LINE_W'(MAX_DIM);
    localparam logic [LINE_W-1:0] MAX_SP   = LINE_W'(FW);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SPWAIT = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]           state;
    logic                 err_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 a_pend;
    logic                 b_pend;
    logic                 start_pend;
    logic [15:0]          control_q;
    logic [FW-1:0]        flags_q;
    logic                 busy_q;

    logic [4:0]           region;
    logic [LINE_W-1:0]    line;
    logic                 is_ctrl;
    logic                 is_opa;
    logic                 is_opb;
    logic                 is_flags;
    logic                 is_sp;
    logic                 is_op;
    logic                 err;
    logic                 access;
    logic                 start_req;
    logic [BUS_WIDTH-1:0] rd_val;

    assign region   = paddr_i[4:0];
    assign line     = paddr_i[ADDR_WIDTH-1:5];
    assign is_ctrl  = (region == 5'h00);
    assign is_opa   = (region == 5'h04);
    assign is_opb   = (region == 5'h08);
    assign is_flags = (region == 5'h0C);
    assign is_sp    = region[4] && (region[1:0] == 2'b00);
    assign is_op    = is_opa || is_opb;

    assign access = (state == IDLE) && psel_i && penable_i;

    always_comb begin
        err = 1'b0;
        if (!(is_ctrl || is_op || is_flags || is_sp))
            err = 1'b1;
        if (pwrite_i && (is_flags || is_sp))
            err = 1'b1;
        if (!pwrite_i && is_op)
            err = 1'b1;
        if (pwrite_i && busy_q && (is_ctrl || is_op))
            err = 1'b1;
        if (is_op && (line >= MAX_LINE))
            err = 1'b1;
        if (is_sp && (line >= MAX_SP))
            err = 1'b1;
    end

    assign start_req = pwrite_i && is_ctrl && !err
                    && pstrb_i[0] && pwdata_i[0];

    // Read data for non-scratchpad reads is captured at decode;
    // scratchpad data arrives during SPWAIT instead.
    always_comb begin
        rd_val = '0;
        if (!err && !pwrite_i) begin
            if (is_ctrl)
                rd_val = {{(BUS_WIDTH-16){1'b0}}, control_q};
            else if (is_flags)
                rd_val = BUS_WIDTH'(flags_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            a_pend     <= 1'b0;
            b_pend     <= 1'b0;
            start_pend <= 1'b0;
            control_q  <= '0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
            op_line_o  <= '0;
            op_wdata_o <= '0;
            op_wstrb_o <= '0;
            sp_sel_o   <= '0;
            sp_addr_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        err_q      <= err;
                        rdata_q    <= rd_val;
                        a_pend     <= !err && pwrite_i && is_opa;
                        b_pend     <= !err && pwrite_i && is_opb;
                        start_pend <= start_req;
                        if (!err && is_op) begin
                            op_line_o  <= line[LW-1:0];
                            op_wdata_o <= pwdata_i;
                            op_wstrb_o <= pstrb_i;
                        end
                        // Bit 0 is the start trigger and never reads back as 1.
                        if (!err && pwrite_i && is_ctrl) begin
                            if (pstrb_i[0])
                                control_q[7:0] <= {pwdata_i[7:1], 1'b0};
                            if (pstrb_i[1])
                                control_q[15:8] <= pwdata_i[15:8];
                        end
                        if (!err && is_sp) begin
                            sp_sel_o  <= paddr_i[3:2];
                            sp_addr_o <= line[SW-1:0];
                            state     <= SPWAIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                SPWAIT: begin
                    rdata_q <= sp_rdata_i;
                    state   <= RESP;
                end
                RESP: begin
                    err_q      <= 1'b0;
                    rdata_q    <= '0;
                    a_pend     <= 1'b0;
                    b_pend     <= 1'b0;
                    start_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Busy rises as RESP begins so it coincides with start_o;
            // a done pulse during that start cycle loses to the start.
            if (access && start_req) begin
                busy_q  <= 1'b1;
                flags_q <= '0;
            end else if (start_o) begin
                busy_q <= 1'b1;
            end else if (done_i && busy_q) begin
                busy_q  <= 1'b0;
                flags_q <= flags_i;
            end
        end
    end

    assign pready_o   = (state == RESP);
    assign pslverr_o  = pready_o && err_q;
    assign prdata_o   = pready_o ? rdata_q : '0;
    assign a_we_o     = pready_o && a_pend;
    assign b_we_o     = pready_o && b_pend;
    assign start_o    = pready_o && start_pend;
    assign busy_o     = busy_q;
    assign control_o  = control_q;
    assign sp_rd_en_o = (state == SPWAIT);

endmodule
